// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: FSM states, captured request record, sizing helper.
package dmem_pkg;

   typedef enum logic [2:0] {
      CLEAR,
      IDLE,
      WAIT,
      ACCESS,
      RESP
   } state_e;

   localparam int unsigned BYTE_LANES = 4;

   // Widest index the responder supports (65536 words); narrower configs use the low bits.
   localparam int unsigned IDX_MAX_W = 16;

   typedef struct packed {
      logic                  is_st;
      logic [IDX_MAX_W-1:0]  index;
      logic [31:0]           wdata;
      logic [BYTE_LANES-1:0] be;
      logic                  err;
   } req_t;

   function automatic int unsigned idx_width(input int unsigned depth_words);
      return $clog2(depth_words);
   endfunction

endpackage

// File: rtl/dmem_word_array.sv
// Single-port DEPTH_WORDS x 32 word store with per-byte write enables and a registered read port.
// Read data changes only on a read or an explicit zeroing cycle, so it holds across response stalls.
module dmem_word_array
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           en_i,
   input  logic                           we_i,
   input  logic [BYTE_LANES-1:0]          be_i,
   input  logic [$clog2(DEPTH_WORDS)-1:0] addr_i,
   input  logic [31:0]                    wdata_i,
   input  logic                           rd_zero_i,
   output logic [31:0]                    rdata_o
);

   logic [31:0] mem_q [DEPTH_WORDS];
   logic [31:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (en_i && we_i) begin
         for (int b = 0; b < BYTE_LANES; b++) begin
            if (be_i[b]) begin
               mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rdata_q <= '0;
      end else if (rd_zero_i) begin
         rdata_q <= '0;
      end else if (en_i && !we_i) begin
         rdata_q <= mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Slow data memory for the load/store path: accept, wait LATENCY cycles, one access, held response.
// Response stalls until resp_ready; `define DMEM_MISALIGN_TRAP_EN makes unaligned addresses errors.
module data_mem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned LATENCY     = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_is_st,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_be,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        busy
);

   localparam int unsigned IW = idx_width(DEPTH_WORDS);

   state_e          state_q;
   logic [IW-1:0]   clear_idx_q;
   logic [3:0]      wait_cnt_q;
   req_t            req_q;
   req_t            req_d;
   logic            req_ready_q;
   logic            resp_valid_q;
   logic            resp_err_q;
   logic            busy_q;
   logic            addr_err;

   logic                  arr_en;
   logic                  arr_we;
   logic [BYTE_LANES-1:0] arr_be;
   logic [IW-1:0]         arr_addr;
   logic [31:0]           arr_wdata;
   logic                  arr_rd_zero;
   logic [31:0]           arr_rdata;

   logic unused_bits;

   always_comb begin
      addr_err = |req_addr[31:IW+2];
`ifdef DMEM_MISALIGN_TRAP_EN
      addr_err = addr_err | (req_addr[1:0] != 2'b00);
`endif
      req_d = '{is_st: req_is_st,
                index: IDX_MAX_W'(req_addr[IW+1:2]),
                wdata: req_wdata,
                be:    req_be,
                err:   addr_err};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= CLEAR;
         clear_idx_q  <= '0;
         wait_cnt_q   <= '0;
         req_q        <= '0;
         req_ready_q  <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         busy_q       <= 1'b1;
      end else begin
         case (state_q)
            CLEAR: begin
               clear_idx_q <= clear_idx_q + 1'b1;
               if (clear_idx_q == IW'(DEPTH_WORDS - 1)) begin
                  state_q     <= IDLE;
                  req_ready_q <= 1'b1;
                  busy_q      <= 1'b0;
               end
            end
            IDLE: begin
               if (req_valid && req_ready_q) begin
                  req_q       <= req_d;
                  req_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
                  if (LATENCY == 0) begin
                     state_q <= ACCESS;
                  end else begin
                     state_q    <= WAIT;
                     wait_cnt_q <= 4'(LATENCY - 1);
                  end
               end
            end
            WAIT: begin
               if (wait_cnt_q == 4'd0) begin
                  state_q <= ACCESS;
               end else begin
                  wait_cnt_q <= wait_cnt_q - 1'b1;
               end
            end
            ACCESS: begin
               state_q      <= RESP;
               resp_valid_q <= 1'b1;
               resp_err_q   <= req_q.err;
            end
            RESP: begin
               if (resp_ready) begin
                  state_q      <= IDLE;
                  resp_valid_q <= 1'b0;
                  req_ready_q  <= 1'b1;
                  busy_q       <= 1'b0;
               end
            end
            default: begin
               state_q <= CLEAR;
            end
         endcase
      end
   end

   // The array port is owned by the CLEAR sweep or by ACCESS; stores and errors zero the read register.
   always_comb begin
      arr_en      = 1'b0;
      arr_we      = 1'b0;
      arr_be      = '0;
      arr_addr    = clear_idx_q;
      arr_wdata   = '0;
      arr_rd_zero = 1'b0;
      if (state_q == CLEAR) begin
         arr_en = 1'b1;
         arr_we = 1'b1;
         arr_be = '1;
      end else if (state_q == ACCESS) begin
         arr_addr    = req_q.index[IW-1:0];
         arr_wdata   = req_q.wdata;
         arr_be      = req_q.be;
         arr_en      = ~req_q.err;
         arr_we      = req_q.is_st;
         arr_rd_zero = req_q.is_st | req_q.err;
      end
   end

   dmem_word_array #(
      .DEPTH_WORDS (DEPTH_WORDS)
   ) u_array (
      .clk_i     (clk),
      .rst_i     (reset),
      .en_i      (arr_en),
      .we_i      (arr_we),
      .be_i      (arr_be),
      .addr_i    (arr_addr),
      .wdata_i   (arr_wdata),
      .rd_zero_i (arr_rd_zero),
      .rdata_o   (arr_rdata)
   );

   assign unused_bits = ^{req_addr[1:0], req_q.index};

   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_rdata = arr_rdata;
   assign resp_err   = resp_err_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder (DEPTH_WORDS=16, LATENCY=2) with hand-computed expectations.
module tb_data_mem_responder;

   localparam int unsigned DEPTH = 16;
   localparam int unsigned LAT   = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_is_st;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_be;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        busy;

   int checks = 0;
   int errors = 0;

   data_mem_responder #(
      .DEPTH_WORDS (DEPTH),
      .LATENCY     (LAT)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_is_st  (req_is_st),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_be     (req_be),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: observed no finish, required finish before 500000");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives one request, returns the response fields and the number of edges after the accept edge
   // until resp_valid is seen (LAT+1 when resp_valid first shows in cycle T+LAT+2).
   task automatic do_req(input logic st, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] be, output logic [31:0] rd, output logic er,
                         output int lat);
      int n;
      n = 0;
      while (req_ready !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      req_valid = 1'b1;
      req_is_st = st;
      req_addr  = a;
      req_wdata = wd;
      req_be    = be;
      tick();
      req_valid = 1'b0;
      req_addr  = 32'hFFFF_FFFF;
      req_wdata = 32'h5A5A_5A5A;
      lat = 0;
      while (resp_valid !== 1'b1 && lat < 50) begin
         tick();
         lat++;
      end
      rd = resp_rdata;
      er = resp_err;
   endtask

   task automatic finish_resp(input string tag);
      tick();
      check({tag, "_vld_drop"}, {31'd0, resp_valid}, 32'd0);
      check({tag, "_rdy_back"}, {31'd0, req_ready}, 32'd1);
   endtask

   logic [31:0] rd;
   logic        er;
   int          lat;
   int          edges;
   logic        seen_vld;

   initial begin
      reset      = 1'b1;
      req_valid  = 1'b0;
      req_is_st  = 1'b0;
      req_addr   = '0;
      req_wdata  = '0;
      req_be     = '0;
      resp_ready = 1'b1;

      tick();
      tick();
      check("rst_req_ready",  {31'd0, req_ready},  32'd0);
      check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      check("rst_resp_rdata", resp_rdata,          32'd0);
      check("rst_resp_err",   {31'd0, resp_err},   32'd0);
      check("rst_busy",       {31'd0, busy},       32'd1);

      // Deassert between edges: edges 1..16 clear words 0..15, req_ready is seen after edge 16 (cycle 17).
      @(negedge clk);
      reset = 1'b0;
      edges = 0;
      while (req_ready !== 1'b1 && edges < 100) begin
         tick();
         edges++;
      end
      check("clear_len", edges, DEPTH);
      check("idle_busy", {31'd0, busy}, 32'd0);

      do_req(1'b0, 32'h0000_003C, 32'h0, 4'h0, rd, er, lat);
      check("ld3c_lat",   lat, LAT + 1);
      check("ld3c_rdata", rd, 32'h0000_0000);
      check("ld3c_err",   {31'd0, er}, 32'd0);
      finish_resp("ld3c");

      do_req(1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 4'hF, rd, er, lat);
      check("st8_lat",   lat, LAT + 1);
      check("st8_rdata", rd, 32'h0);
      check("st8_err",   {31'd0, er}, 32'd0);
      finish_resp("st8");

      do_req(1'b0, 32'h0000_0008, 32'h0, 4'h0, rd, er, lat);
      check("ld8_lat",   lat, LAT + 1);
      check("ld8_rdata", rd, 32'hDEAD_BEEF);
      finish_resp("ld8");

      do_req(1'b1, 32'h0000_0008, 32'h1122_3344, 4'b0101, rd, er, lat);
      finish_resp("stp");
      do_req(1'b0, 32'h0000_0008, 32'h0, 4'h0, rd, er, lat);
      check("ldp_rdata", rd, 32'hDE22_BE44);

      finish_resp("ldp");
      do_req(1'b1, 32'h0000_0008, 32'hFFFF_FFFF, 4'b0000, rd, er, lat);
      check("st_be0_err", {31'd0, er}, 32'd0);
      finish_resp("stbe0");
      do_req(1'b0, 32'h0000_0008, 32'h0, 4'h0, rd, er, lat);
      check("ld_be0_rdata", rd, 32'hDE22_BE44);
      finish_resp("ldbe0");

      do_req(1'b0, 32'h0000_0040, 32'h0, 4'h0, rd, er, lat);
      check("oor40_err",   {31'd0, er}, 32'd1);
      check("oor40_rdata", rd, 32'h0);
      finish_resp("oor40");
      do_req(1'b0, 32'h0001_0000, 32'h0, 4'h0, rd, er, lat);
      check("oor10000_err",   {31'd0, er}, 32'd1);
      check("oor10000_rdata", rd, 32'h0);
      finish_resp("oor10000");
      do_req(1'b1, 32'h0000_0040, 32'hAAAA_AAAA, 4'hF, rd, er, lat);
      check("oorst_err", {31'd0, er}, 32'd1);
      finish_resp("oorst");
      do_req(1'b0, 32'h0000_0000, 32'h0, 4'h0, rd, er, lat);
      check("oorst_no_alias", rd, 32'h0);
      check("ld0_err", {31'd0, er}, 32'd0);
      finish_resp("ld0");

      do_req(1'b0, 32'h0000_0009, 32'h0, 4'h0, rd, er, lat);
`ifdef DMEM_MISALIGN_TRAP_EN
      check("mis9_err",   {31'd0, er}, 32'd1);
      check("mis9_rdata", rd, 32'h0);
`else
      check("mis9_err",   {31'd0, er}, 32'd0);
      check("mis9_rdata", rd, 32'hDE22_BE44);
`endif
      finish_resp("mis9");

      resp_ready = 1'b0;
      do_req(1'b0, 32'h0000_0008, 32'h0, 4'h0, rd, er, lat);
      check("bp_first_rdata", rd, 32'hDE22_BE44);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp_hold_vld",   {31'd0, resp_valid}, 32'd1);
         check("bp_hold_rdata", resp_rdata, 32'hDE22_BE44);
         check("bp_hold_rdy",   {31'd0, req_ready}, 32'd0);
      end
      resp_ready = 1'b1;
      finish_resp("bp");

      // Abort a store while it is still waiting; nothing may be written or answered.
      req_valid = 1'b1;
      req_is_st = 1'b1;
      req_addr  = 32'h0000_0004;
      req_wdata = 32'hCAFE_F00D;
      req_be    = 4'hF;
      tick();
      req_valid = 1'b0;
      tick();
      check("abort_in_wait", {31'd0, busy}, 32'd1);
      reset = 1'b1;
      #1;
      check("abort_rdy",  {31'd0, req_ready},  32'd0);
      check("abort_vld",  {31'd0, resp_valid}, 32'd0);
      tick();
      tick();
      @(negedge clk);
      reset    = 1'b0;
      edges    = 0;
      seen_vld = 1'b0;
      while (req_ready !== 1'b1 && edges < 100) begin
         tick();
         edges++;
         if (resp_valid === 1'b1) seen_vld = 1'b1;
      end
      check("reclear_len", edges, DEPTH);
      check("abort_no_resp", {31'd0, seen_vld}, 32'd0);

      do_req(1'b0, 32'h0000_0004, 32'h0, 4'h0, rd, er, lat);
      check("abort_ld4", rd, 32'h0);
      finish_resp("abort_ld4");
      do_req(1'b0, 32'h0000_0008, 32'h0, 4'h0, rd, er, lat);
      check("reclear_ld8", rd, 32'h0);
      finish_resp("reclear_ld8");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Memory-side responder for the processor's load/store path. Accepts one word load or store request at a time from the memory-access stage over a valid/ready handshake. Models a fixed number of wait cycles and returns read data or a store acknowledgement over a second valid/ready channel. Replaces the zero-latency combinational data memory, so the datapath can be exercised against a slow, stalling memory.

## Interface
Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words; power of two, 16 to 65536.
- LATENCY, 2: wait cycles between acceptance and memory access; 0 to 15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_is_st  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, little-endian (byte 0 = bits 7:0).
- req_be  in  4  store byte enables; ignored for loads.
- resp_valid  out  1  response present.
- resp_ready  in  1  requester accepts response.
- resp_rdata  out  32  load data; 0 for stores and errors.
- resp_err  out  1  request rejected, with no memory effect.
- busy  out  1  high in every state except IDLE.

## Operation
- Word index = req_addr[log2(DEPTH_WORDS)+1:2].
- Out of range: any set bit in req_addr[31:log2(DEPTH_WORDS)+2] → error.
- States:
  - CLEAR: entered on reset. Writes 0 to one word per cycle, index 0 to DEPTH_WORDS-1. Goes to IDLE after the last word.
  - IDLE: req_ready=1. On req_valid && req_ready, latches is_st, index, wdata, be and error flag. Goes to WAIT if LATENCY>0, else to ACCESS.
  - WAIT: down-counter loaded with LATENCY-1; goes to ACCESS when the counter reaches 0.
  - ACCESS: one cycle.
    - Store without error: writes enabled bytes.
    - Load without error: reads the word into the resp_rdata register.
    - Error: no array access.
    - Goes to RESP.
  - RESP: resp_valid=1, holds rdata and err stable until resp_ready=1. Goes to IDLE on the handshake edge.
- Only one request is ever in flight; req_ready=0 outside IDLE.
- Store with req_be=4'b0000 completes normally (err=0) and changes no memory.
- Memory contents are retained only through the request path. Every reset re-runs CLEAR.

## Timing
- Reset values: req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0, busy=1; state=CLEAR, clear index=0.
- Reset asserted mid-transaction aborts it immediately.
  - A store not yet past its ACCESS edge is never written.
  - No response is produced for the aborted request.
- CLEAR lasts exactly DEPTH_WORDS cycles after reset deassertion; req_ready rises in the following cycle.
- Accept edge = T. ACCESS occupies cycle T+LATENCY+1; resp_valid is first high in cycle T+LATENCY+2.
- With resp_ready held high, the handshake completes in that same cycle and req_ready is high in the next cycle.
- Issue interval is therefore LATENCY+3 cycles per request.
- resp_valid never deasserts without a handshake. resp_ready while resp_valid=0 is ignored.
- req_valid may be held across busy cycles; only the IDLE-cycle value is sampled.

## Configuration
- DMEM_MISALIGN_TRAP_EN defined:
  - req_addr[1:0] != 0 is an error (resp_err=1, rdata=0, no write).
  - Checked in addition to the range check.
- Undefined:
  - req_addr[1:0] is ignored; the access goes to the containing aligned word.
  - Only the range check produces errors.

## Structure
- Shared package dmem_pkg:
  - state enum (CLEAR, IDLE, WAIT, ACCESS, RESP);
  - byte-lane constant 4;
  - index-width function clog2(DEPTH_WORDS);
  - packed request struct (is_st, index, wdata, be, err).
- Sub-module dmem_word_array:
  - single-port synchronous word array, DEPTH_WORDS×32, per-byte write enables, registered read;
  - shared by the CLEAR sweep and ACCESS through a port mux in the parent.

## Test plan
- Reset, then idle with DEPTH_WORDS=16: req_ready first high exactly 17 cycles after reset deassertion; load of address 0x0000003C → rdata 0x00000000, err=0.
- Store 0xDEADBEEF to 0x8 with be=4'b1111, then load 0x8 with LATENCY=2 → load resp_valid high in cycle T+4 after its accept edge T; rdata 0xDEADBEEF.
- Partial store 0x11223344 to 0x8 with be=4'b0101 over 0xDEADBEEF → load returns 0xDE22BE44.
- Load 0x00010000 with DEPTH_WORDS=1024 → err=1, rdata 0. With DMEM_MISALIGN_TRAP_EN, load 0x9 → err=1; without it, load 0x9 returns the word at 0x8.
- Backpressure: hold resp_ready=0 for 5 cycles → resp_valid and rdata stay stable, req_ready=0 throughout; req_ready goes high in the cycle after resp_ready rises.
- Assert reset during WAIT of a store of 0xCAFEF00D to 0x4 → no response; after CLEAR, load 0x4 → 0x00000000.
